// File: rtl/aes_iter_core.sv
// Iterative AES encryptor: one round datapath plus one key-expansion datapath, one round per clock.
// Latency ROUNDS edges from accept to out_valid; define AES_KEY_HOLD_EN to add a reusable key-hold register.
module aes_iter_core #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain,
  input  logic [127:0] key,
  input  logic         key_load,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST = 4'(ROUNDS);

  fsm_t         fsm;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   cnt;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  logic [127:0] init_key;
  logic [127:0] rk_next;
  logic [127:0] st_sr;
  logic [127:0] st_mc;
  logic [127:0] st_next;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as b^254 (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, w4, w5, w6, w7;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w4 = w0 ^ t ^ {rc, 24'h000000};
    w5 = w1 ^ w4;
    w6 = w2 ^ w5;
    w7 = w3 ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  assign accept  = in_valid && in_ready_q;
  assign rk_next = key_expand(rk, rcon(cnt));
  assign st_sr   = sub_shift(st);
  assign st_mc   = mix_columns(st_sr);
  assign st_next = ((cnt == LAST) ? st_sr : st_mc) ^ rk_next;

`ifdef AES_KEY_HOLD_EN
  logic [127:0] key_hold;

  assign init_key = key_load ? key : key_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_hold <= '0;
    end else if (accept && key_load) begin
      key_hold <= key;
    end
  end
`else
  logic unused_key_load;

  assign init_key        = key;
  assign unused_key_load = key_load;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= IDLE;
      st          <= '0;
      rk          <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            st         <= plain ^ init_key;
            rk         <= init_key;
            cnt        <= 4'd1;
            fsm        <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          st <= st_next;
          rk <= rk_next;
          if (cnt == LAST) begin
            fsm         <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm         <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          fsm         <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign cipher    = st;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed and random checks of aes_iter_core against a textbook FIPS-197 model.
module tb_aes_iter_core;

  localparam int ROUNDS = 10;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain;
  logic [127:0] key;
  logic         key_load;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] model_hold = '0;

  aes_iter_core #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plain     (plain),
    .key       (key),
    .key_load  (key_load),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cipher    (cipher),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // S-box generated by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Carry-less product followed by long division by 0x11B.
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (15'h11b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p, input int nr);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rnd != nr) begin
          s[0][c] = mul(t[0][c], 8'h02) ^ mul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ mul(t[1][c], 8'h02) ^ mul(t[2][c], 8'h03) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ mul(t[2][c], 8'h02) ^ mul(t[3][c], 8'h03);
          s[3][c] = mul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ mul(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] eff_key(input logic [127:0] k, input logic kl);
`ifdef AES_KEY_HOLD_EN
    return kl ? k : model_hold;
`else
    return k;
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send(input logic [127:0] k, input logic [127:0] p, input logic kl);
    int n;
    plain    = p;
    key      = k;
    key_load = kl;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", 128'(busy), 128'(1));
`ifdef AES_KEY_HOLD_EN
    if (kl) model_hold = k;
`endif
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_hs", 128'(out_valid), 128'(0));
    check("in_ready_after_hs", 128'(in_ready), 128'(1));
  endtask

  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] p, input logic kl);
    logic [127:0] exp;
    int lat;
    exp = aes_model(eff_key(k, kl), p, ROUNDS);
    send(k, p, kl);
    wait_done(lat);
    check({tag, "_latency"}, 128'(lat), 128'(ROUNDS));
    check({tag, "_cipher"}, cipher, exp);
    handshake();
  endtask

  localparam logic [127:0] P_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [127:0] ka, pa, kb, pb, ea, eb;
    int lat;
    build_sbox();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key_load = 1'b0;
    plain = '0; key = '0;
    tick();
    tick();
    check("rst_cipher", cipher, '0);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;
    tick();

    // Appendix B vector with exact latency.
    send(K_B, P_B, 1'b1);
    wait_done(lat);
    check("fips_b_latency", 128'(lat), 128'(10));
    check("fips_b_cipher", cipher, C_B);
    handshake();

    // Appendix C.1 vector with consumer stalling.
    send(K_C, P_C, 1'b1);
    wait_done(lat);
    check("fips_c_latency", 128'(lat), 128'(10));
    for (int i = 0; i < 5; i++) begin
      check("stall_cipher", cipher, C_C);
      check("stall_in_ready", 128'(in_ready), 128'(0));
      check("stall_out_valid", 128'(out_valid), 128'(1));
      tick();
    end
    handshake();

    // A second block offered during ROUND and DONE must wait for the handshake.
    ka = rand128(); pa = rand128(); kb = rand128(); pb = rand128();
    ea = aes_model(eff_key(ka, 1'b1), pa, ROUNDS);
    eb = aes_model(kb, pb, ROUNDS);
    send(ka, pa, 1'b1);
    plain = pb; key = kb; key_load = 1'b1; in_valid = 1'b1;
    wait_done(lat);
    check("overlap_latency", 128'(lat), 128'(ROUNDS));
    check("overlap_first_cipher", cipher, ea);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("overlap_done_in_ready", 128'(in_ready), 128'(0));
      check("overlap_done_cipher", cipher, ea);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("overlap_in_ready_after_hs", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("overlap_second_busy", 128'(busy), 128'(1));
`ifdef AES_KEY_HOLD_EN
    model_hold = kb;
`endif
    wait_done(lat);
    check("overlap_second_latency", 128'(lat), 128'(ROUNDS));
    check("overlap_second_cipher", cipher, eb);
    handshake();

    // Reset during round 4 aborts the block.
    send(K_B, P_C, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_cipher", cipher, '0);
    check("abort_in_ready", 128'(in_ready), 128'(1));
    check("abort_busy", 128'(busy), 128'(0));
    model_hold = '0;
    tick();
    rst = 1'b0;
    tick();
    send(K_B, P_B, 1'b1);
    wait_done(lat);
    check("post_abort_latency", 128'(lat), 128'(10));
    check("post_abort_cipher", cipher, C_B);
    handshake();

    // Random blocks; key_load varies so the hold path is exercised when built in.
    for (int i = 0; i < 6; i++) begin
      run_block("rand", rand128(), rand128(), (i % 3) != 2);
    end

    // Held key reuse: block 2 presents key port 0 with key_load=0.
    run_block("hold_blk1", K_B, rand128(), 1'b1);
    eb = aes_model(eff_key('0, 1'b0), P_B, ROUNDS);
    send('0, P_B, 1'b0);
    wait_done(lat);
    check("hold_blk2_latency", 128'(lat), 128'(ROUNDS));
    check("hold_blk2_cipher", cipher, eb);
`ifdef AES_KEY_HOLD_EN
    check("hold_blk2_fips", cipher, C_B);
`endif
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 10, giving the number of cipher rounds; legal range 1..10, and ROUNDS=10 is FIPS-197 AES-128.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: plain/key presented.
REQ-005 SHALL have port in_ready, output, 1 bit: core can accept a block.
REQ-006 SHALL have port plain, input, 128 bits: plaintext; bit 127 is byte 0 MSB, FIPS-197 column-major order.
REQ-007 SHALL have port key, input, 128 bits: cipher key, same byte order as plain.
REQ-008 SHALL have port key_load, input, 1 bit: load a new key with this block; used only under AES_KEY_HOLD_EN.
REQ-009 SHALL have port out_valid, output, 1 bit: cipher valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts cipher.
REQ-011 SHALL have port cipher, output, 128 bits: ciphertext.
REQ-012 SHALL have port busy, output, 1 bit: round iteration in progress.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE, and busy=1 only in ROUND.
REQ-015 SHALL accept a block on a rising edge with in_valid&&in_ready, and on that edge SHALL load: state reg = plain XOR key; round-key reg = key; round counter = 1; FSM -> ROUND.
REQ-016 SHALL, on each ROUND edge with counter r, first compute rk' = KeyExpand(rk, Rcon[r]), with Rcon = 01,02,04,08,10,20,40,80,1B,36.
REQ-017 SHALL then update the state as state = SubBytes -> ShiftRows -> MixColumns -> XOR rk', and SHALL store rk' into the round-key reg.
REQ-018 SHALL omit MixColumns on the round where r == ROUNDS (the final round).
REQ-019 SHALL increment the counter after each non-final round, and on the r == ROUNDS edge SHALL move the FSM to DONE.
REQ-020 SHALL raise out_valid exactly ROUNDS clock edges after the accept edge, i.e. 10 edges for the default.
REQ-021 SHALL drive cipher directly from the state reg and hold it stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on an edge with out_valid&&out_ready, move DONE -> IDLE, making in_ready=1 on the next cycle; there is no overlap between an accept and a DONE handshake.
REQ-023 SHALL ignore in_valid, plain, key and key_load outside IDLE.
REQ-024 SHALL ignore out_ready outside DONE.
REQ-025 SHALL implement KeyExpand as: w4 = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
REQ-026 SHALL implement all byte arithmetic in GF(2^8) with polynomial 0x11B.
REQ-027 SHALL instantiate one round datapath and one key-expansion datapath only, with no unrolling.

Reset
REQ-028 SHALL, while rst=1, asynchronously force: FSM = IDLE, state reg = 0, round-key reg = 0, key-hold reg = 0, counter = 0.
REQ-029 SHALL give these output values during reset: cipher=0, out_valid=0, busy=0, in_ready=1.
REQ-030 SHALL, on rst asserted mid-ROUND or in DONE, abort the block with no output; the first accept after release SHALL start a fresh block.

Configuration
REQ-031 SHALL, with AES_KEY_HOLD_EN defined, add a 128-bit key-hold reg, written on accept when key_load=1.
REQ-032 SHALL, with AES_KEY_HOLD_EN defined, take the initial key from the key-hold reg on an accept with key_load=0, and from the key port when key_load=1.
REQ-033 SHALL, without AES_KEY_HOLD_EN, omit the key-hold reg, ignore key_load, and sample the key port on every accept.

Verification
REQ-034 SHALL cover: ROUNDS=10, plain=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> cipher=3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 edges after accept.
REQ-035 SHALL cover: plain=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> cipher=69c4e0d86a7b0430d8cdb78070b4c55a; and, with out_ready held 0 for 5 cycles, cipher stable and in_ready=0 throughout.
REQ-036 SHALL cover: in_valid=1 with new plain during ROUND -> ignored; the first result is unchanged and the second block is accepted only after the DONE handshake.
REQ-037 SHALL cover: rst pulsed at round 4 -> out_valid=0, cipher=0, in_ready=1 immediately; the next block yields the correct FIPS value.
REQ-038 SHALL cover, with AES_KEY_HOLD_EN: block 1 with key_load=1 and key 2b7e..4f3c, then block 2 with key_load=0, key port = 0, and plain 3243..0734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-039 SHALL cover, without AES_KEY_HOLD_EN: the same block 2 stimulus -> cipher equals AES(key=0, plain 3243..0734) from the reference model.
